// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster engine. Generates h/v counters, pixel-RAM
// read address/strobe, and a latency-matched output stage that re-aligns sync,
// display-enable and line/frame pulses with the RAM read data. State advances on pix_ce only.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int COLOR_W  = 4,
    parameter int RD_LAT   = 1,
    parameter int X_W      = 10,
    parameter int Y_W      = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pix_ce,
    input  logic                 en,
    input  logic [3*COLOR_W-1:0] din,
    output logic [Y_W-1:0]       row,
    output logic [X_W-1:0]       col,
    output logic                 rdn,
    output logic [COLOR_W-1:0]   r,
    output logic [COLOR_W-1:0]   g,
    output logic [COLOR_W-1:0]   b,
    output logic                 hs,
    output logic                 vs,
    output logic                 de,
    output logic                 line_start,
    output logic                 frame_start
);

    localparam int H_TOT       = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOT       = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_W         = $clog2(H_TOT + 1);
    localparam int V_W         = $clog2(V_TOT + 1);
    localparam int H_ACT_START = H_SYNC + H_BP;
    localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;
    localparam int V_ACT_START = V_SYNC + V_BP;
    localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;

    // Side-band bundle carried alongside the RAM read: {hs, vs, de, line, frame}
    localparam int M_HS = 4;
    localparam int M_VS = 3;
    localparam int M_DE = 2;
    localparam int M_LS = 1;
    localparam int M_FS = 0;
    localparam logic [4:0] META_IDLE = {~HS_POL, ~VS_POL, 3'b000};

    logic [H_W-1:0]       r_h;
    logic [V_W-1:0]       r_v;
    logic [Y_W-1:0]       r_row;
    logic [X_W-1:0]       r_col;
    logic                 r_rdn;
    logic [4:0]           r_meta [RD_LAT];
    logic [COLOR_W-1:0]   r_r;
    logic [COLOR_W-1:0]   r_g;
    logic [COLOR_W-1:0]   r_b;
    logic                 r_hs;
    logic                 r_vs;
    logic                 r_de;
    logic                 r_lineStart;
    logic                 r_frameStart;

    logic                 w_hAct;
    logic                 w_vAct;
    logic                 w_active;
    logic                 w_hsLevel;
    logic                 w_vsLevel;
    logic [X_W-1:0]       w_colNext;
    logic [Y_W-1:0]       w_rowNext;
    logic [4:0]           w_metaNext;
    logic [4:0]           w_metaOut;

    // Raster counters; en low parks the raster at the frame origin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (pix_ce) begin
            if (!en) begin
                r_h <= '0;
                r_v <= '0;
            end else if (r_h == H_W'(H_TOT - 1)) begin
                r_h <= '0;
                r_v <= (r_v == V_W'(V_TOT - 1)) ? '0 : r_v + V_W'(1);
            end else begin
                r_h <= r_h + H_W'(1);
            end
        end
    end

    // Region decode for the current counter position, blanked when the raster is stopped
    always_comb begin
        w_hAct     = (r_h >= H_W'(H_ACT_START)) && (r_h < H_W'(H_ACT_END));
        w_vAct     = (r_v >= V_W'(V_ACT_START)) && (r_v < V_W'(V_ACT_END));
        w_active   = en && w_hAct && w_vAct;
        w_hsLevel  = (r_h < H_W'(H_SYNC)) ? HS_POL : ~HS_POL;
        w_vsLevel  = (r_v < V_W'(V_SYNC)) ? VS_POL : ~VS_POL;
        w_colNext  = X_W'(r_h - H_W'(H_ACT_START));
        w_rowNext  = Y_W'(r_v - V_W'(V_ACT_START));
        w_metaNext = META_IDLE;
        if (en) begin
            w_metaNext = {w_hsLevel, w_vsLevel, w_hAct && w_vAct,
                          r_h == '0, (r_h == '0) && (r_v == '0)};
        end
    end

    // Stage A: RAM address and read strobe, zero address outside the active window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
            r_rdn <= 1'b1;
        end else if (pix_ce) begin
            if (w_active) begin
                r_row <= w_rowNext;
                r_col <= w_colNext;
                r_rdn <= 1'b0;
            end else begin
                r_row <= '0;
                r_col <= '0;
                r_rdn <= 1'b1;
            end
        end
    end

    // Side-band delay line; entry 0 is loaded alongside stage A, the tail meets din
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_meta[i] <= META_IDLE;
            end
        end else if (pix_ce) begin
            r_meta[0] <= w_metaNext;
            for (int i = 1; i < RD_LAT; i++) begin
                r_meta[i] <= r_meta[i-1];
            end
        end
    end

    assign w_metaOut = r_meta[RD_LAT-1];

    // Output register: colour gated by de, pulses self-clear on the following clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r          <= '0;
            r_g          <= '0;
            r_b          <= '0;
            r_hs         <= ~HS_POL;
            r_vs         <= ~VS_POL;
            r_de         <= 1'b0;
            r_lineStart  <= 1'b0;
            r_frameStart <= 1'b0;
        end else begin
            r_lineStart  <= 1'b0;
            r_frameStart <= 1'b0;
            if (pix_ce) begin
                r_hs         <= w_metaOut[M_HS];
                r_vs         <= w_metaOut[M_VS];
                r_de         <= w_metaOut[M_DE];
                r_lineStart  <= w_metaOut[M_LS];
                r_frameStart <= w_metaOut[M_FS];
                if (w_metaOut[M_DE]) begin
                    r_r <= din[COLOR_W-1:0];
                    r_g <= din[2*COLOR_W-1:COLOR_W];
                    r_b <= din[3*COLOR_W-1:2*COLOR_W];
                end else begin
                    r_r <= '0;
                    r_g <= '0;
                    r_b <= '0;
                end
            end
        end
    end

    assign row         = r_row;
    assign col         = r_col;
    assign rdn         = r_rdn;
    assign r           = r_r;
    assign g           = r_g;
    assign b           = r_b;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign de          = r_de;
    assign line_start  = r_lineStart;
    assign frame_start = r_frameStart;

endmodule
